// File: rtl/alu_pkg.sv
// Shared widths, opcodes, FSM encoding and the command payload for the ALU command issuer.
package alu_pkg;
   localparam int OPND_W = 4;
   localparam int RES_W  = 8;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_MUL = 3'b010;
   localparam logic [OP_W-1:0] OP_DIV = 3'b011;
   localparam logic [OP_W-1:0] OP_AND = 3'b100;
   localparam logic [OP_W-1:0] OP_OR  = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
   } cmd_t;

   // Error status: divide by zero, or an opcode above OP_OR.
   function automatic logic cmd_err(input logic [OP_W-1:0] op, input logic [OPND_W-1:0] b);
      return ((op == OP_DIV) && (b == '0)) || (op > OP_OR);
   endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  cmd_t wdata_i,
   input  logic pop_i,
   output cmd_t rdata_o,
   output logic full_o,
   output logic empty_o
);
   localparam int AW = $clog2(DEPTH);

   cmd_t        mem_q [DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic        do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues host ALU commands, issues them one at a time to the ALU pins, waits out the
// ALU latency and returns the captured result with error status on a response stream.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OPND_W-1:0] cmd_a,
   input  logic [OPND_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   output logic [OPND_W-1:0] alu_a,
   output logic [OPND_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [RES_W-1:0]  alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_data,
   output logic [OP_W-1:0]   rsp_op,
   output logic              rsp_err,
   output logic              busy
);
   localparam int CNT_W = $clog2(ALU_LAT + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   cmd_t             push_cmd, head;
   logic             full, empty, pop, capture;
   logic [OPND_W-1:0] alu_a_q, alu_b_q;
   logic [OP_W-1:0]   alu_op_q, rsp_op_q;
   logic [RES_W-1:0]  rsp_data_q;
   logic              rsp_err_q;

   assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_valid),
      .wdata_i (push_cmd),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: if (!empty) begin
            pop     = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: if (cnt_q == CNT_W'(ALU_LAT)) begin
            capture = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: if (rsp_ready) begin
            // Chain straight into the next command to avoid an IDLE bubble.
            pop     = !empty;
            state_d = empty ? ST_IDLE : ST_EXEC;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_op_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            cnt_q    <= '0;
         end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (capture) begin
            rsp_data_q <= alu_result;
            rsp_op_q   <= alu_op_q;
            rsp_err_q  <= cmd_err(alu_op_q, alu_b_q);
         end
      end
   end

   assign cmd_ready = !full;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_op    = rsp_op_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE) || !empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and random checks of alu_cmd_issuer against a queue-based response model,
// with behavioural ALUs of latency 1 and 3.
module tb_alu_cmd_issuer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [3:0] cmd_a = '0, cmd_b = '0;
   logic [2:0] cmd_op = '0;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [2:0] rsp_op;
   logic       rsp_err, busy;

   logic       c3_valid = 1'b0, c3_ready;
   logic [3:0] c3_a = '0, c3_b = '0, c3_alu_a, c3_alu_b;
   logic [2:0] c3_op = '0, c3_alu_op, c3_rsp_op;
   logic [7:0] c3_alu_result, c3_rsp_data;
   logic       c3_rsp_valid, c3_rsp_err, c3_busy;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy));

   alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
      .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op),
      .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_op(c3_alu_op), .alu_result(c3_alu_result),
      .rsp_valid(c3_rsp_valid), .rsp_ready(1'b1), .rsp_data(c3_rsp_data),
      .rsp_op(c3_rsp_op), .rsp_err(c3_rsp_err), .busy(c3_busy));

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] ea, eb;
      ea = {4'b0, a};
      eb = {4'b0, b};
      case (op)
         3'd0: return ea + eb;
         3'd1: return ea - eb;
         3'd2: return ea * eb;
         3'd3: return (b == 0) ? 8'hFF : ea / eb;
         3'd4: return ea & eb;
         3'd5: return ea | eb;
         default: return 8'h00;
      endcase
   endfunction

   // Behavioural ALUs: result registered ALU_LAT edges after the operands are sampled.
   logic [7:0] p3_0, p3_1, p3_2;
   always @(posedge clk) begin
      alu_result <= alu_f(alu_op, alu_a, alu_b);
      p3_0 <= alu_f(c3_alu_op, c3_alu_a, c3_alu_b);
      p3_1 <= p3_0;
      p3_2 <= p3_1;
   end
   assign c3_alu_result = p3_2;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] op;
      logic       err;
      logic [3:0] a;
      logic [3:0] b;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] got_data[$];
   logic [2:0] got_op[$];
   logic       got_err[$];
   int         rsp_cyc[$];
   int         n_chk = 0, n_fail = 0, n_rsp = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge with this cycle's inputs applied; records the
   // handshakes that the coming posedge performs, then advances to the next negedge.
   task automatic tick();
      exp_t e;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_count", 32'(n_rsp + 1), 32'(n_rsp));
         end else begin
            e = exp_q.pop_front();
            chk("rsp_payload", {rsp_data, rsp_op, rsp_err}, {e.data, e.op, e.err});
            chk("alu_pins_held", {alu_a, alu_b, alu_op}, {e.a, e.b, e.op});
         end
         got_data.push_back(rsp_data);
         got_op.push_back(rsp_op);
         got_err.push_back(rsp_err);
         rsp_cyc.push_back(cyc);
         n_rsp++;
      end
      if (cmd_valid && cmd_ready) begin
         e.data = alu_f(cmd_op, cmd_a, cmd_b);
         e.op   = cmd_op;
         e.err  = (cmd_op == 3'd3 && cmd_b == 0) || (cmd_op >= 3'd6);
         e.a    = cmd_a;
         e.b    = cmd_b;
         exp_q.push_back(e);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int n;
      n = 0;
      while (n_rsp < target && n < budget) begin
         tick();
         n++;
      end
      chk("wait_rsp_timeout", 32'(n_rsp >= target), 32'd1);
   endtask

   initial begin
      int         idx, base, n;
      logic       fire, seen;
      logic [11:0] held;

      // Reset state
      @(negedge clk);
      rst = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp", {rsp_valid, rsp_data, rsp_op, rsp_err}, 0);
      chk("rst_alu", {alu_a, alu_b, alu_op}, 0);

      // Single add and latency
      rsp_ready = 1'b1;
      send(4'd5, 4'd3, 3'd0);
      for (int i = 0; i < 3; i++) begin
         chk("lat_not_yet", rsp_valid, 0);
         tick();
      end
      chk("lat_valid", rsp_valid, 1);
      chk("add_data", rsp_data, 8);
      chk("add_op_err", {rsp_op, rsp_err}, 0);
      tick();
      chk("busy_after_add", busy, 0);

      // Back-to-back
      base = n_rsp;
      rsp_cyc.delete();
      cmd_a = 4'd9;  cmd_b = 4'd4;  cmd_op = 3'd1; cmd_valid = 1'b1; tick();
      cmd_a = 4'd15; cmd_b = 4'd15; cmd_op = 3'd2; tick();
      cmd_a = 4'd12; cmd_b = 4'd10; cmd_op = 3'd4; tick();
      cmd_valid = 1'b0;
      wait_rsp(base + 3, 40);
      chk("b2b_r0", got_data[base], 5);
      chk("b2b_r1", got_data[base+1], 225);
      chk("b2b_r2", got_data[base+2], 8);
      chk("b2b_gap0", 32'(rsp_cyc[1] - rsp_cyc[0]), 3);
      chk("b2b_gap1", 32'(rsp_cyc[2] - rsp_cyc[1]), 3);

      // Backpressure
      rsp_ready = 1'b0;
      idx = 0;
      seen = 1'b0;
      held = '0;
      for (int i = 0; i < 20; i++) begin
         cmd_valid = (idx < 7);
         cmd_a = 4'(idx + 1); cmd_b = 4'(idx + 2); cmd_op = 3'(idx % 6);
         fire = cmd_valid && cmd_ready;
         if (rsp_valid && !seen) begin
            seen = 1'b1;
            held = {rsp_data, rsp_op, rsp_err};
         end
         tick();
         if (fire) idx++;
      end
      chk("bp_accepted", 32'(idx), 5);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_held", {rsp_data, rsp_op, rsp_err}, held);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      base = n_rsp;
      wait_rsp(base + 5, 60);
      chk("bp_cmd_ready_after", cmd_ready, 1);

      // Error cases
      base = n_rsp;
      send(4'd7, 4'd0, 3'd3);
      send(4'd3, 4'd2, 3'd6);
      wait_rsp(base + 2, 30);
      chk("div0_err_op", {got_err[base], got_op[base]}, {1'b1, 3'd3});
      chk("op6_err_data", {got_err[base+1], got_data[base+1]}, {1'b1, 8'd0});

      // Reset mid-EXEC with two queued
      cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 3'd0; cmd_valid = 1'b1; tick();
      cmd_a = 4'd2; tick();
      cmd_a = 4'd3; tick();
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_alu", {alu_a, alu_b, alu_op}, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      base = n_rsp;
      for (int i = 0; i < 10; i++) tick();
      chk("no_stale_rsp", 32'(n_rsp), 32'(base));
      send(4'd2, 4'd6, 3'd0);
      wait_rsp(base + 1, 20);
      chk("post_rst_data", got_data[base], 8);

      // ALU_LAT=3 instance
      c3_a = 4'd1; c3_b = 4'd1; c3_op = 3'd0; c3_valid = 1'b1;
      tick();
      c3_valid = 1'b0;
      n = 0;
      while (!c3_rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("lat3_latency", 32'(n), 5);
      chk("lat3_data", {c3_rsp_data, c3_rsp_err}, {8'd2, 1'b0});

      // Random traffic against the response queue
      for (int i = 0; i < 300; i++) begin
         cmd_valid = ($urandom_range(0, 9) < 6);
         cmd_a     = 4'($urandom);
         cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
         cmd_op    = 3'($urandom_range(0, 7));
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("rand_drained", 32'(exp_q.size()), 0);
      chk("rand_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the 4-bit-operand / 3-bit-opcode ALU interface. It buffers operation requests from a host valid/ready stream, drives operands and opcode onto the ALU pins one operation at a time, and waits out the ALU's registered latency. It then captures the 8-bit result and returns it with status on a valid/ready response stream. It sits between the host-side command decoder and the ALU core.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
ALU_LAT, 1, ALU result latency in clock edges after operands are sampled (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  command accepted when valid&ready at posedge
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_op  input  3  opcode (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or)
alu_a  output  4  ALU operand A (registered)
alu_b  output  4  ALU operand B (registered)
alu_op  output  3  ALU opcode (registered)
alu_result  input  8  ALU registered result
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid&ready at posedge
rsp_data  output  8  captured ALU result
rsp_op  output  3  opcode that produced rsp_data
rsp_err  output  1  1 = divide-by-zero or unsupported opcode
busy  output  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst=1): FIFO emptied; state=IDLE; alu_a/alu_b/alu_op=0; rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0; cmd_ready=1 once rst deasserts; busy=0. Reset mid-operation drops all pending and in-flight commands. Outputs clear immediately, not at the next edge.
- Command FIFO: push on cmd_valid&cmd_ready. cmd_ready = !full; no push-through when full, even if a pop occurs in the same cycle. A push into an empty FIFO is visible to the FSM on the next cycle. No bypass.
- FSM states IDLE, EXEC, RESP.
- IDLE: if FIFO non-empty, pop head at the edge, load alu_a/alu_b/alu_op from it, clear cnt, go to EXEC.
- EXEC: alu_a/alu_b/alu_op are held stable for the whole state. cnt increments each edge. At the edge where cnt==ALU_LAT, capture the following and go to RESP:
  - rsp_data <= alu_result
  - rsp_op <= alu_op
  - rsp_err <= (alu_op==011 && alu_b==0) || alu_op>=110
- RESP: rsp_valid=1; rsp_data/rsp_op/rsp_err are stable until the handshake.
  - On rsp_ready with FIFO non-empty: pop next head, load ALU pins, go to EXEC (no IDLE bubble).
  - On rsp_ready with FIFO empty: go to IDLE.
  - Without rsp_ready: hold indefinitely (backpressure). The FIFO keeps accepting commands while not full.
- Latency with ALU_LAT=1: accept edge A; EXEC entered at A+1; capture at A+3. rsp_valid is high in the cycle after edge A+3.
- Throughput with rsp_ready held high: one response per ALU_LAT+2 cycles.
- ALU pins keep their last values in IDLE and RESP; they are not zeroed.
- Errors do not stall the block. rsp_data carries whatever the ALU produced.
- Capacity under full backpressure: DEPTH queued commands plus 1 held in RESP.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR
  - OPND_W=4, RES_W=8, OP_W=3
  - FSM state encoding
- One natural sub-module: alu_cmd_fifo, a synchronous FIFO with parameter DEPTH, a 11-bit payload {op,a,b}, full/empty flags and async active-high reset.

Test Plan:
- Reset, then send a=5 b=3 op=000 with rsp_ready=1, using a behavioural ALU model (ALU_LAT=1) -> rsp_valid exactly 4 edges after the accept edge (asserted in the cycle after accept edge + 3); rsp_data=8, rsp_op=000, rsp_err=0; busy returns to 0.
- Back-to-back: sub 9-4, mul 15*15, and 12&10 queued, rsp_ready=1 -> responses 5, 225, 8 in order, spaced 3 cycles apart; alu_* stable across every EXEC cycle.
- Backpressure: rsp_ready=0, present 7 commands continuously -> 5 accepted, then cmd_ready=0; the first response is held unchanged. Release rsp_ready -> all 5 drain in order, then cmd_ready=1.
- Divide by zero: a=7 b=0 op=011 -> rsp_err=1, rsp_op=011. Op 110 with a=3 b=2 -> rsp_err=1, rsp_data=0 (model returns 0).
- Reset asserted mid-EXEC with 2 commands queued -> same-cycle rsp_valid=0, alu_*=0, busy=0. After release, no stale responses; a new command completes normally.
- ALU_LAT=3 build: single add 1+1 -> capture 4 edges after EXEC entry; rsp_data=2.
